serial_adder: RTL and testbench

Parametrised bit-serial adder: accepts two WIDTH-bit operands on a start pulse, adds them LSB-first through a single one-bit full-adder cell over WIDTH clock cycles, and presents a registered sum and carry-out with a one-cycle done strobe. It is the area-minimal, multi-width successor to the lab's single-bit adder cells. It sits as a leaf arithmetic unit driven by a controller that issues start and waits for done.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_fulladder.sv | 21 ++
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// FSM encoding and counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..width.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit full-adder cell built from gate primitives.
// Shared by every bit position of the serial adder.
module fulladder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output wire  s,
  output wire  c
);

  wire p;
  wire g;
  wire t;

  xor u_x0 (p, x, y);
  xor u_x1 (s, p, cin);
  and u_a0 (g, x, y);
  and u_a1 (t, p, cin);
  or  u_o0 (c, g, t);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit operands summed LSB-first
// through one full-adder cell, one bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] ps;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH:0]   ps_ext;
  logic [WIDTH-1:0] ps_nxt;
  logic             last;

  fulladder u_fa (
    .x   (ra[0]),
    .y   (rb[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

  // New sum bit enters at the MSB; works for WIDTH=1 too.
  assign ps_ext = {fa_s, ps};
  assign ps_nxt = ps_ext[WIDTH:1];
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      ps    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            ps    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ADD: begin
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          ps    <= ps_nxt;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum   <= ps_nxt;
            cout  <= fa_c;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances
// checked every cycle against a latency/arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [7:0] sum8;
  logic       cout8;
  logic       busy8;
  logic       done8;

  logic       start1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       sum1;
  logic       cout1;
  logic       busy1;
  logic       done1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .sum   (sum8),
    .cout  (cout8),
    .busy  (busy8),
    .done  (done8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .sum   (sum1),
    .cout  (cout1),
    .busy  (busy1),
    .done  (done1)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: a started op completes exactly w edges later
  // with (a+b) split into sum mod 2^w and carry.
  logic       m_busy[2];
  logic       m_done[2];
  int         m_rem[2];
  logic [7:0] m_sum[2];
  logic       m_cout[2];
  logic [7:0] m_a[2];
  logic [7:0] m_b[2];

  task automatic model_step(input int i, input int w,
                            input logic r, input logic st,
                            input logic [7:0] av,
                            input logic [7:0] bv);
    int res;
    int mask;
    mask = (1 << w) - 1;
    if (r) begin
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
      m_rem[i]  = 0;
      m_sum[i]  = '0;
      m_cout[i] = 1'b0;
    end else begin
      m_done[i] = 1'b0;
      if (m_busy[i]) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          res = int'(m_a[i]) + int'(m_b[i]);
          m_sum[i]  = 8'(res & mask);
          m_cout[i] = ((res >> w) & 1) != 0;
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
        end
      end else if (st) begin
        m_busy[i] = 1'b1;
        m_rem[i]  = w;
        m_a[i]    = 8'(int'(av) & mask);
        m_b[i]    = 8'(int'(bv) & mask);
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    model_step(0, 8, rst, start8, a8, b8);
    model_step(1, 1, rst, start1, {7'd0, a1}, {7'd0, b1});
  end

  always @(negedge clk) begin
    check("sum8",  32'(sum8),  32'(m_sum[0]));
    check("cout8", 32'(cout8), 32'(m_cout[0]));
    check("busy8", 32'(busy8), 32'(m_busy[0]));
    check("done8", 32'(done8), 32'(m_done[0]));
    check("sum1",  32'(sum1),  32'(m_sum[1][0]));
    check("cout1", 32'(cout1), 32'(m_cout[1]));
    check("busy1", 32'(busy1), 32'(m_busy[1]));
    check("done1", 32'(done1), 32'(m_done[1]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op8(input logic [7:0] av,
                           input logic [7:0] bv);
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  // Bounded wait for done; lat counts edges after the start edge.
  task automatic wait_done(input int i, output int lat,
                           output int busy_n);
    logic seen;
    seen = 1'b0;
    lat = 0;
    busy_n = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if ((i == 0) ? busy8 : busy1) busy_n++;
      tick();
      lat++;
      if ((i == 0) ? done8 : done1) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  int lat;
  int bn;
  int nd;

  initial begin
    repeat (3) tick();
    check("rst_sum",  32'(sum8),  32'h0);
    check("rst_cout", 32'(cout8), 32'h0);
    check("rst_busy", 32'(busy8), 32'h0);
    check("rst_done", 32'(done8), 32'h0);
    rst = 1'b0;
    tick();

    start_op8(8'h5A, 8'h3C);
    wait_done(0, lat, bn);
    check("t1_lat",  32'(lat),   32'd8);
    check("t1_busy", 32'(bn),    32'd8);
    check("t1_sum",  32'(sum8),  32'h96);
    check("t1_cout", 32'(cout8), 32'h0);
    check("t1_model", 32'(m_sum[0]), 32'h96);
    tick();
    check("t1_done_fall", 32'(done8), 32'h0);

    start_op8(8'hFF, 8'h01);
    wait_done(0, lat, bn);
    check("t2_sum",  32'(sum8),  32'h00);
    check("t2_cout", 32'(cout8), 32'h1);
    tick();
    start_op8(8'h00, 8'h00);
    wait_done(0, lat, bn);
    check("t2b_sum",  32'(sum8),  32'h00);
    check("t2b_cout", 32'(cout8), 32'h0);
    tick();

    start_op8(8'h0F, 8'h01);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin
        start8 = 1'b1;
        a8 = 8'h11;
        b8 = 8'h22;
      end else begin
        start8 = 1'b0;
      end
      tick();
      if (done8) nd++;
      if (c == 7) begin
        check("t3_sum",  32'(sum8),  32'h10);
        check("t3_cout", 32'(cout8), 32'h0);
      end
    end
    check("t3_ndone", 32'(nd), 32'd1);

    a8 = 8'h01;
    b8 = 8'h02;
    start8 = 1'b1;
    tick();
    wait_done(0, lat, bn);
    check("t4a_sum", 32'(sum8), 32'h03);
    a8 = 8'h80;
    b8 = 8'h80;
    tick();
    start8 = 1'b0;
    check("t4_busy", 32'(busy8), 32'h1);
    check("t4_done", 32'(done8), 32'h0);
    wait_done(0, lat, bn);
    check("t4_lat",  32'(lat),   32'd8);
    check("t4_sum",  32'(sum8),  32'h00);
    check("t4_cout", 32'(cout8), 32'h1);
    tick();

    start_op8(8'h0F, 8'hF0);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("t5_sum",  32'(sum8),  32'h0);
    check("t5_cout", 32'(cout8), 32'h0);
    check("t5_busy", 32'(busy8), 32'h0);
    check("t5_done", 32'(done8), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    start_op8(8'h03, 8'h04);
    wait_done(0, lat, bn);
    check("t5_sum2", 32'(sum8), 32'h07);
    tick();

    a1 = 1'b1;
    b1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done(1, lat, bn);
    check("w1_lat",  32'(lat),   32'd1);
    check("w1_sum",  32'(sum1),  32'h0);
    check("w1_cout", 32'(cout1), 32'h1);
    tick();
    a1 = 1'b1;
    b1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done(1, lat, bn);
    check("w1b_sum",  32'(sum1),  32'h1);
    check("w1b_cout", 32'(cout1), 32'h0);
    tick();

    for (int c = 0; c < 400; c++) begin
      start8 = ($urandom % 3) == 0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      start1 = ($urandom % 2) == 0;
      a1 = 1'($urandom);
      b1 = 1'($urandom);
      tick();
    end
    start8 = 1'b0;
    start1 = 1'b0;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
